// File: rtl/ser_pkg.sv
// Shared serial-line definitions used by the transmitter and the matching receiver.
package ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_e;

  localparam logic SER_IDLE_LEVEL  = 1'b1;
  localparam logic SER_START_LEVEL = 1'b0;

endpackage

// File: rtl/ser_tx_if.sv
// Word handshake into the serial transmitter: producer is master, transmitter is slave.
interface ser_tx_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period counter: tick marks the last clk cycle of each serial bit while run is high.
module ser_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  // With CLKS_PER_BIT == 1, LAST is 0 and the counter stays at 0, so tick is constant 1.
  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (!run || tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ser_tx.sv
// Framed parallel-to-serial transmitter: start 0, data LSB first, optional even parity, stop 1.
// Define SER_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module ser_tx
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic     clk,
  input  logic     reset,
  ser_tx_if.slave  bus,
  output logic     out,
  output logic     busy
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             live_q;
  logic             tick, timer_run, ready_c, accept, load;
`ifdef SER_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign timer_run = (state_q != IDLE);

  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (timer_run),
    .tick  (tick)
  );

  // live_q keeps ready low while reset is held, even though state is already IDLE.
  assign ready_c       = live_q & ((state_q == IDLE) | ((state_q == STOP) & tick));
  assign bus.din_ready = ready_c;
  assign accept        = bus.din_valid & ready_c;
  assign out           = out_q;
  assign busy          = busy_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    load    = 1'b0;
`ifdef SER_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE:  load = accept;
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef SER_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          load    = accept;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      shreg_d = bus.din;
      idx_d   = '0;
`ifdef SER_TX_PARITY_EN
      parity_d = ^bus.din;
`endif
    end

    // Line level follows the state being entered so out is registered with no extra lag.
    case (state_d)
      START:   out_d = SER_START_LEVEL;
      DATA:    out_d = shreg_d[0];
`ifdef SER_TX_PARITY_EN
      PARITY:  out_d = parity_q;
`endif
      default: out_d = SER_IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      out_q   <= SER_IDLE_LEVEL;
      busy_q  <= 1'b0;
      live_q  <= 1'b0;
`ifdef SER_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      live_q  <= 1'b1;
`ifdef SER_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
